// File: rtl/mkio_rt_controller.sv
// MKIO remote-terminal message controller. Decodes command words addressed to
// this terminal (or broadcast receives), moves data words between the bus and
// per-subaddress buffers, returns the status word and reports message outcome.
module mkio_rt_controller #(
    parameter logic [4:0] ADDRESS    = 5'd1,
    parameter int         NUM_SA     = 4,
    parameter bit         BCAST_EN   = 1'b1,
    parameter int         RX_TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [15:0]       rx_data,
    input  logic              rx_cd,
    input  logic              p_error,
    output logic              tx_ready,
    output logic [15:0]       tx_data,
    output logic              tx_cd,
    input  logic              tx_busy,
    input  logic [4:0]        host_sa,
    input  logic [4:0]        host_addr,
    input  logic [15:0]       host_wdata,
    input  logic              host_we,
    output logic [15:0]       host_rdata,
    output logic [NUM_SA-1:0] busy_sa,
    output logic              msg_done,
    output logic              msg_error,
    output logic [4:0]        msg_sa,
    output logic [5:0]        msg_wc,
    output logic              msg_tr
);
    localparam int SA_W = (NUM_SA > 1) ? $clog2(NUM_SA) : 1;
    localparam int TO_W = $clog2(RX_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RX_DATA, TX_STATUS, WAIT_TX, TX_DATA} state_e;

    state_e          state_q, state_d;
    logic            me_q, me_d, bcr_q, bcr_d, bcast_q, bcast_d, tr_q, tr_d;
    logic [4:0]      sa_q, sa_d;
    logic [5:0]      wc_q, wc_d, word_q, word_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            seen_busy_q, seen_busy_d;
    logic            tx_ready_q, tx_ready_d, tx_cd_q, tx_cd_d;
    logic [15:0]     sw_q, sw_d;
    logic            done_q, done_d, error_q, error_d;
    logic [15:0]     host_rdata_q;
    logic [15:0]     tx_rd_q;
    logic            rx_we, tx_rd;

    logic [15:0] rx_buf [NUM_SA][32];
    logic [15:0] tx_buf [NUM_SA][32];

    // Command word decode; mode code 2 (transmit status word) must not disturb ME/BCR.
    logic       cw_bcast, cw_accept, cw_mode, cw_legal, cw_keep;
    logic [4:0] cw_sa;
    logic [5:0] cw_wc;
    assign cw_sa     = rx_data[9:5];
    assign cw_bcast  = BCAST_EN && (rx_data[15:11] == 5'd31) && !rx_data[10];
    assign cw_accept = rx_done && !rx_cd && !p_error && ((rx_data[15:11] == ADDRESS) || cw_bcast);
    assign cw_mode   = (cw_sa == 5'd0) || (cw_sa == 5'd31);
    assign cw_legal  = (cw_sa >= 5'd1) && (cw_sa <= 5'(NUM_SA));
    assign cw_wc     = (rx_data[4:0] == 5'd0) ? 6'd32 : {1'b0, rx_data[4:0]};
    assign cw_keep   = cw_mode && (rx_data[4:0] == 5'd2);

    // Current-message qualifiers.
    logic            legal_q, more_words, host_legal;
    logic [SA_W-1:0] sa_idx, host_idx;
    logic [15:0]     status_word;
    assign legal_q     = (sa_q >= 5'd1) && (sa_q <= 5'(NUM_SA));
    assign sa_idx      = SA_W'(sa_q - 5'd1);
    assign more_words  = tr_q && legal_q && (word_q < wc_q);
    assign host_legal  = (host_sa >= 5'd1) && (host_sa <= 5'(NUM_SA));
    assign host_idx    = SA_W'(host_sa - 5'd1);
    assign status_word = {ADDRESS, me_q, 5'd0, bcr_q, 4'd0};

    // Next-state, status-flag and transmit-strobe logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        me_d        = me_q;
        bcr_d       = bcr_q;
        bcast_d     = bcast_q;
        tr_d        = tr_q;
        sa_d        = sa_q;
        wc_d        = wc_q;
        word_d      = word_q;
        to_cnt_d    = to_cnt_q;
        seen_busy_d = seen_busy_q;
        tx_ready_d  = 1'b0;
        tx_cd_d     = tx_cd_q;
        sw_d        = sw_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        rx_we       = 1'b0;
        tx_rd       = 1'b0;

        if (cw_accept) begin
            // A new command always wins; any message in progress is reported as aborted.
            error_d     = (state_q != IDLE);
            sa_d        = cw_sa;
            wc_d        = cw_wc;
            tr_d        = rx_data[10];
            bcast_d     = cw_bcast;
            word_d      = '0;
            to_cnt_d    = '0;
            seen_busy_d = 1'b0;
            if (!cw_keep) begin
                me_d  = !cw_mode && !cw_legal;
                bcr_d = cw_bcast;
            end
            if (!rx_data[10] && !cw_mode) begin
                state_d = RX_DATA;
            end else if (cw_bcast) begin
                state_d = IDLE;             // broadcast mode code: never answered
                done_d  = 1'b1;
            end else begin
                state_d = TX_STATUS;
            end
        end else begin
            case (state_q)
                RX_DATA: begin
                    if (rx_done) begin
                        to_cnt_d = '0;
                        if (!rx_cd || p_error) begin
                            me_d    = 1'b1;
                            error_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            rx_we  = legal_q;   // illegal SA: words consumed, not stored
                            word_d = word_q + 6'd1;
                            if (word_d == wc_q) begin
                                if (bcast_q) begin
                                    state_d = IDLE;
                                    done_d  = !me_q;
                                    error_d = me_q;
                                end else begin
                                    state_d = TX_STATUS;
                                end
                            end
                        end
                    end else if (to_cnt_q == TO_W'(RX_TIMEOUT)) begin
                        me_d    = 1'b1;
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                TX_STATUS: begin
                    if (!tx_busy) begin
                        sw_d        = status_word;
                        tx_cd_d     = 1'b0;
                        tx_ready_d  = 1'b1;
                        seen_busy_d = 1'b0;
                        state_d     = WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (tx_busy) begin
                        seen_busy_d = 1'b1;
                    end else if (seen_busy_q) begin
                        if (more_words) begin
                            state_d = TX_DATA;
                        end else begin
                            state_d = IDLE;
                            done_d  = !me_q;
                            error_d = me_q;
                        end
                    end
                end
                TX_DATA: begin
                    // Buffer read is issued here; data and tx_ready appear together next cycle.
                    if (!tx_busy) begin
                        tx_rd       = 1'b1;
                        tx_cd_d     = 1'b1;
                        tx_ready_d  = 1'b1;
                        word_d      = word_q + 6'd1;
                        seen_busy_d = 1'b0;
                        state_d     = WAIT_TX;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q      <= IDLE;
            me_q         <= 1'b0;
            bcr_q        <= 1'b0;
            bcast_q      <= 1'b0;
            tr_q         <= 1'b0;
            sa_q         <= '0;
            wc_q         <= '0;
            word_q       <= '0;
            to_cnt_q     <= '0;
            seen_busy_q  <= 1'b0;
            tx_ready_q   <= 1'b0;
            tx_cd_q      <= 1'b0;
            sw_q         <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            me_q         <= me_d;
            bcr_q        <= bcr_d;
            bcast_q      <= bcast_d;
            tr_q         <= tr_d;
            sa_q         <= sa_d;
            wc_q         <= wc_d;
            word_q       <= word_d;
            to_cnt_q     <= to_cnt_d;
            seen_busy_q  <= seen_busy_d;
            tx_ready_q   <= tx_ready_d;
            tx_cd_q      <= tx_cd_d;
            sw_q         <= sw_d;
            done_q       <= done_d;
            error_q      <= error_d;
            host_rdata_q <= host_legal ? rx_buf[host_idx][host_addr] : 16'd0;
        end
    end

    // Message buffers: bus receive writes, host transmit-buffer writes, transmit read.
    always_ff @(posedge clk) begin
        // NOTE: buffer storage carries no reset; contents are undefined until written.
        if (rx_we)
            rx_buf[sa_idx][word_q[4:0]] <= rx_data;
        if (host_we && host_legal)
            tx_buf[host_idx][host_addr] <= host_wdata;
        if (tx_rd)
            tx_rd_q <= tx_buf[sa_idx][word_q[4:0]];
    end

    // Subaddress activity flags for data messages only.
    always_comb begin
        busy_sa = '0;
        if (state_q != IDLE && legal_q)
            busy_sa[sa_idx] = 1'b1;
    end

    assign tx_ready   = tx_ready_q;
    assign tx_cd      = tx_cd_q;
    assign tx_data    = tx_cd_q ? tx_rd_q : sw_q;
    assign host_rdata = host_rdata_q;
    assign msg_done   = done_q;
    assign msg_error  = error_q;
    assign msg_sa     = sa_q;
    assign msg_wc     = wc_q;
    assign msg_tr     = tr_q;
endmodule

// File: tb/tb_mkio_rt_controller.sv
// Directed bench for mkio_rt_controller: a small transmitter model answers
// tx_ready with a busy window and logs every transmitted word.
module tb_mkio_rt_controller;
    localparam int NUM_SA     = 4;
    localparam int RX_TIMEOUT = 1000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_done = 1'b0;
    logic [15:0]       rx_data = '0;
    logic              rx_cd = 1'b0;
    logic              p_error = 1'b0;
    logic              tx_ready;
    logic [15:0]       tx_data;
    logic              tx_cd;
    logic              tx_busy = 1'b0;
    logic [4:0]        host_sa = '0;
    logic [4:0]        host_addr = '0;
    logic [15:0]       host_wdata = '0;
    logic              host_we = 1'b0;
    logic [15:0]       host_rdata;
    logic [NUM_SA-1:0] busy_sa;
    logic              msg_done, msg_error;
    logic [4:0]        msg_sa;
    logic [5:0]        msg_wc;
    logic              msg_tr;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_viol = 0;
    logic [15:0]       tx_words[$];
    logic              tx_cds[$];
    logic [NUM_SA-1:0] tx_bsa[$];

    mkio_rt_controller #(
        .ADDRESS(5'd1), .NUM_SA(NUM_SA), .BCAST_EN(1'b1), .RX_TIMEOUT(RX_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_cd(rx_cd),
        .p_error(p_error), .tx_ready(tx_ready), .tx_data(tx_data), .tx_cd(tx_cd),
        .tx_busy(tx_busy), .host_sa(host_sa), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_we(host_we), .host_rdata(host_rdata),
        .busy_sa(busy_sa), .msg_done(msg_done), .msg_error(msg_error),
        .msg_sa(msg_sa), .msg_wc(msg_wc), .msg_tr(msg_tr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outcome pulse counters.
    always @(negedge clk) begin
        if (msg_done)  done_cnt++;
        if (msg_error) err_cnt++;
    end

    // Transmitter model: logs each word, then stays busy for three cycles.
    initial begin
        int left;
        left = 0;
        forever begin
            @(negedge clk);
            if (tx_ready) begin
                if (tx_busy) busy_viol++;
                tx_words.push_back(tx_data);
                tx_cds.push_back(tx_cd);
                tx_bsa.push_back(busy_sa);
                tx_busy = 1'b1;
                left = 3;
            end else if (left > 0) begin
                left--;
                if (left == 0) tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send(input logic cd, input logic [15:0] data, input logic perr);
        @(negedge clk);
        rx_done = 1'b1; rx_cd = cd; rx_data = data; p_error = perr;
        @(negedge clk);
        rx_done = 1'b0; p_error = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k;
        k = 0;
        while (tx_words.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_txcount"}, tx_words.size(), n);
    endtask

    task automatic host_read(input logic [4:0] sa, input logic [4:0] addr,
                             input logic [15:0] exp, input string tag);
        @(negedge clk);
        host_sa = sa; host_addr = addr;
        @(negedge clk);
        check(tag, host_rdata, exp);
    endtask

    task automatic clear_log();
        tx_words.delete(); tx_cds.delete(); tx_bsa.delete();
    endtask

    initial begin
        int d0, e0, k, bad_bsa, bad_cd;

        // Reset state.
        settle(3);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy_sa", busy_sa, 0);
        check("rst_msg", {msg_done, msg_error, msg_sa, msg_wc, msg_tr}, 0);
        check("rst_host_rdata", host_rdata, 0);
        @(negedge clk); reset = 1'b1;
        settle(2);

        // Receive SA2, 4 words.
        d0 = done_cnt;
        send(1'b0, 16'h0844, 1'b0);
        send(1'b1, 16'h1111, 1'b0);
        send(1'b1, 16'h2222, 1'b0);
        check("rx_busy_sa", busy_sa, 4'b0010);
        send(1'b1, 16'h3333, 1'b0);
        send(1'b1, 16'h4444, 1'b0);
        wait_tx(1, "rx1");
        settle(10);
        check("rx1_one_word", tx_words.size(), 1);
        check("rx1_sw", tx_words[0], 16'h0800);
        check("rx1_sw_cd", tx_cds[0], 0);
        check("rx1_done", done_cnt - d0, 1);
        check("rx1_fields", {msg_sa, msg_wc, msg_tr}, {5'd2, 6'd4, 1'b0});
        check("rx1_idle_busy", busy_sa, 0);
        for (int i = 0; i < 4; i++)
            host_read(5'd2, 5'(i), 16'h1111 * 16'(i + 1), "rx1_host");
        host_read(5'd7, 5'd0, 16'h0000, "host_illegal_sa");

        // Transmit SA3, WC=32.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            host_we = 1'b1; host_sa = 5'd3; host_addr = 5'(i); host_wdata = 16'hA000 + 16'(i);
        end
        @(negedge clk); host_we = 1'b0;
        clear_log();
        d0 = done_cnt;
        send(1'b0, 16'h0C60, 1'b0);
        wait_tx(33, "tx32");
        settle(10);
        check("tx32_sw", tx_words[0], 16'h0800);
        bad_bsa = 0; bad_cd = 0;
        for (int i = 0; i < 33; i++) begin
            if (tx_bsa[i] !== 4'b0100) bad_bsa++;
            if (tx_cds[i] !== (i != 0)) bad_cd++;
        end
        for (int i = 1; i < 33; i++)
            check("tx32_data", tx_words[i], 16'hA000 + 16'(i - 1));
        check("tx32_busy_sa", bad_bsa, 0);
        check("tx32_cd", bad_cd, 0);
        check("tx32_ready_while_busy", busy_viol, 0);
        check("tx32_done", done_cnt - d0, 1);
        check("tx32_fields", {msg_sa, msg_wc, msg_tr}, {5'd3, 6'd32, 1'b1});

        // Parity error on data word 2, then transmit-status mode code.
        clear_log();
        e0 = err_cnt;
        send(1'b0, 16'h0823, 1'b0);
        send(1'b1, 16'h1234, 1'b0);
        send(1'b1, 16'hDEAD, 1'b1);
        settle(20);
        check("perr_error", err_cnt - e0, 1);
        check("perr_no_sw", tx_words.size(), 0);
        check("perr_busy_sa", busy_sa, 0);
        host_read(5'd1, 5'd0, 16'h1234, "perr_kept_word");
        send(1'b0, 16'h0C02, 1'b0);
        wait_tx(1, "mode2a");
        settle(10);
        check("mode2_sw_me", tx_words[0], 16'h0C00);
        send(1'b0, 16'h0C02, 1'b0);
        wait_tx(2, "mode2b");
        settle(10);
        check("mode2_me_sticky", tx_words[1], 16'h0C00);

        // Broadcast receive, then status with BCR.
        clear_log();
        d0 = done_cnt;
        send(1'b0, 16'hF844, 1'b0);
        for (int i = 0; i < 4; i++) send(1'b1, 16'h5A00 + 16'(i), 1'b0);
        settle(20);
        check("bcast_no_tx", tx_words.size(), 0);
        check("bcast_done", done_cnt - d0, 1);
        host_read(5'd2, 5'd0, 16'h5A00, "bcast_w0");
        host_read(5'd2, 5'd3, 16'h5A03, "bcast_w3");
        send(1'b0, 16'h0C02, 1'b0);
        wait_tx(1, "bcr");
        settle(10);
        check("bcr_sw", tx_words[0], 16'h0810);

        // Inter-word timeout.
        clear_log();
        send(1'b0, 16'h0825, 1'b0);
        send(1'b1, 16'h0A0A, 1'b0);
        send(1'b1, 16'h0B0B, 1'b0);
        e0 = err_cnt;
        k = 0;
        while (err_cnt == e0 && k < RX_TIMEOUT + 50) begin
            @(negedge clk);
            k++;
        end
        check("timeout_error", err_cnt - e0, 1);
        check("timeout_not_early", k >= RX_TIMEOUT - 4, 1);
        check("timeout_no_sw", tx_words.size(), 0);
        check("timeout_busy_sa", busy_sa, 0);

        // New command mid-message aborts and restarts.
        e0 = err_cnt; d0 = done_cnt;
        send(1'b0, 16'h0825, 1'b0);
        send(1'b1, 16'h0101, 1'b0);
        send(1'b1, 16'h0202, 1'b0);
        send(1'b0, 16'h0842, 1'b0);
        check("abort_error", err_cnt - e0, 1);
        check("abort_busy_sa", busy_sa, 4'b0010);
        send(1'b1, 16'h7777, 1'b0);
        send(1'b1, 16'h8888, 1'b0);
        wait_tx(1, "restart");
        settle(10);
        check("restart_sw", tx_words[0], 16'h0800);
        check("restart_done", done_cnt - d0, 1);
        host_read(5'd2, 5'd0, 16'h7777, "restart_w0");
        host_read(5'd2, 5'd1, 16'h8888, "restart_w1");
        host_read(5'd1, 5'd0, 16'h0101, "aborted_kept");

        // Reset while in TX_DATA.
        clear_log();
        send(1'b0, 16'h0C60, 1'b0);
        wait_tx(3, "rst_tx");
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (tx_busy && k < 50);
        #2;
        check("pre_rst_busy_sa", busy_sa, 4'b0100);
        reset = 1'b0;
        #1;
        check("mid_rst_tx_ready", tx_ready, 0);
        check("mid_rst_busy_sa", busy_sa, 0);
        check("mid_rst_msg", {msg_sa, msg_wc, msg_tr}, 0);
        check("mid_rst_host_rdata", host_rdata, 0);
        settle(3);
        reset = 1'b1;
        settle(30);
        check("post_rst_no_tx", tx_words.size(), 3);
        d0 = done_cnt;
        send(1'b0, 16'h0C02, 1'b0);
        wait_tx(4, "post_rst");
        settle(10);
        check("post_rst_sw", tx_words[3], 16'h0800);
        check("post_rst_done", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mkio_rt_controller.md
Name: mkio_rt_controller

Overview:
- Parametrised MKIO remote-terminal (RT) message controller.
- Sits between the MKIO word receiver/transmitter and host logic.
- Decodes command words (CW) addressed to this RT for any subaddress 1..NUM_SA, in both directions; ordinary broadcast receive and mode codes are also handled.
- Sequences data words and builds the status word (SW); holds per-subaddress receive and transmit buffers that the host accesses through a single-clock port.

Parameters:
- ADDRESS, 5'd1: own RT address.
- NUM_SA, 4: number of data subaddresses (1..NUM_SA legal), range 1..30.
- BCAST_EN, 1: accept broadcast address 5'd31 receive commands.
- RX_TIMEOUT, 1000: max clk cycles between consecutive received data words.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_done  in  1  one-cycle pulse: received word valid on rx_data/rx_cd/p_error.
- rx_data  in  16  received word.
- rx_cd  in  1  sync type: 0 = command/status sync, 1 = data sync.
- p_error  in  1  parity/Manchester error on current word.
- tx_ready  out  1  one-cycle pulse: start transmission of tx_data.
- tx_data  out  16  word to transmit.
- tx_cd  out  1  0 = status sync, 1 = data sync.
- tx_busy  in  1  transmitter busy.
- host_sa  in  5  host buffer subaddress.
- host_addr  in  5  host word index.
- host_wdata  in  16  host write data (transmit buffer).
- host_we  in  1  host write strobe.
- host_rdata  out  16  host read data (receive buffer), 1-cycle latency.
- busy_sa  out  NUM_SA  bit k-1 high while subaddress k message is in progress.
- msg_done  out  1  one-cycle pulse: message completed without error.
- msg_error  out  1  one-cycle pulse: message aborted or illegal.
- msg_sa  out  5  subaddress of last message.
- msg_wc  out  6  word count of last message, 1..32.
- msg_tr  out  1  T/R bit of last message.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; state IDLE.
  - ME and BCR flags cleared.
  - Buffer contents undefined.
- CW accepted when: rx_done & ~rx_cd & ~p_error & (rx_data[15:11]==ADDRESS or (BCAST_EN & rx_data[15:11]==31 & rx_data[10]==0)).
  - CW fields: T/R=[10] (1 = RT transmits); SA=[9:5]; WC=[4:0], with 0 meaning 32.
  - Acceptance is evaluated in every state. A new accepted CW aborts any message in progress: msg_error pulses, then the new CW is taken.
- Status word: [15:11]=ADDRESS, [10]=ME, [9:5]=0, [4]=BCR, [3:0]=0.
- On CW acceptance:
  - ME is cleared, except for mode code 5'd2.
  - BCR is set when the CW is broadcast, cleared otherwise.
  - msg_sa/msg_wc/msg_tr are latched.
- States:
  - IDLE: wait for CW. Legal SA with T/R=0 -> RX_DATA. Legal SA with T/R=1 -> TX_STATUS. SA 0 or 31 (mode code) -> TX_STATUS, no data words. Illegal SA (>NUM_SA and not 31) -> ME=1; data words for receive are consumed without writing, then TX_STATUS; for transmit, status only.
  - RX_DATA: each rx_done with rx_cd=1 writes rx_data to rx_buf[SA][n], n=0..WC-1; n wraps only by restart. After word WC -> TX_STATUS, or IDLE if broadcast (no response). Errors: p_error on a data word, a CW (rx_cd=0) not addressed here, or RX_TIMEOUT cycles without rx_done. Any error: ME=1, msg_error pulse, -> IDLE, no status sent. Words already written stay in the buffer.
  - TX_STATUS: wait tx_busy=0, then pulse tx_ready with tx_data=SW, tx_cd=0 -> WAIT_TX.
  - WAIT_TX: wait for tx_busy to rise, then fall. Next state: TX_DATA if words remain in a transmit message, else IDLE with msg_done (or msg_error if ME).
  - TX_DATA: tx_data=tx_buf[SA][n], tx_cd=1, tx_ready pulse -> WAIT_TX; n increments; WC words total.
- Buffer read timing: tx_data must be stable from the tx_ready cycle until tx_busy rises. The buffer read is issued one cycle before the pulse.
- busy_sa[SA-1] is high from the cycle after CW acceptance until return to IDLE. It is never high for mode codes or illegal SAs.
- Host port:
  - host_we writes tx_buf[host_sa][host_addr].
  - host_rdata = rx_buf[host_sa][host_addr] registered, one cycle after the address is presented.
  - Host writes during busy are performed; avoiding them is a host obligation.
  - host_sa outside 1..NUM_SA: write ignored, rdata=0.
- rx_done ignored while in TX_STATUS/WAIT_TX/TX_DATA, except for an accepted CW.

Test Plan:
- Receive CW 0x0844 (addr 1, R, SA2, WC4) + data 0x1111..0x4444 -> SW 0x0800 once, msg_done; host reads SA2 words 0..3 = 0x1111..0x4444 one cycle after address.
- Host writes SA3 words 0..31 = 0xA000+i; CW 0x0C60 (T, SA3, WC0=32) -> SW 0x0800, then 32 data words 0xA000..0xA01F, each tx_ready pulse issued only after tx_busy fell; busy_sa[2] high throughout.
- Receive CW WC=3 with p_error on word 2 -> no SW, msg_error pulse; then mode CW 0x0C02 (T, SA0, mode 2) -> SW 0x0C00 (ME=1), and ME stays set.
- Broadcast CW 0xF844 with 4 words -> no tx_ready; next CW 0x0C02 returns SW 0x0810 (BCR=1).
- Receive CW WC=5, stall after 2 words for RX_TIMEOUT cycles -> msg_error, IDLE; a new CW mid-message aborts and restarts cleanly.
- reset low during TX_DATA -> tx_ready=0, busy_sa=0 immediately, IDLE after release.
